// File: rtl/release_gate_stage.sv
// -----------------------------------------------------------------------------
// release_gate_stage
//
// Purpose:
//   Registered consumer of an upstream result pair (in1/in2). Nonzero pairs are
//   buffered in a small FIFO and released one word at a time on a valid/ready
//   port. Release is only possible inside an authorization window opened by
//   auth and lasting TIMEOUT cycles, so data only reaches out_data after auth
//   has been seen recently.
//
// Parameters:
//   WIDTH    word width of in1/in2/out_data
//   DEPTH    FIFO entries (pairs), power of 2, >= 2
//   TIMEOUT  window length in cycles after auth, 1..255
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in1, in2     result pair from upstream
//   in_valid     pair is sampled this cycle
//   auth         opens / refreshes the release window (level)
//   out_data     released word
//   out_src      0 = word came from in1, 1 = from in2
//   out_valid    out_data valid
//   out_ready    consumer accepts when out_valid & out_ready
//   window_open  FSM is ARMED or HOLD
//   fifo_level   number of stored pair entries
//   dropped_cnt  (RELEASE_AUDIT_EN only) saturating count of dropped pairs
//
// Build option:
//   RELEASE_AUDIT_EN  when defined, adds the dropped_cnt output port.
// -----------------------------------------------------------------------------
module release_gate_stage #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in1,
    input  logic [WIDTH-1:0]         in2,
    input  logic                     in_valid,
    input  logic                     auth,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     window_open,
`ifdef RELEASE_AUDIT_EN
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               dropped_cnt
`else
    output logic [$clog2(DEPTH):0]   fifo_level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        ARMED  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Pair storage (no reset needed: only entries below level are ever read)
    logic [WIDTH-1:0] mem_in1_reg [DEPTH];
    logic [WIDTH-1:0] mem_in2_reg [DEPTH];

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             phase_reg;   // half of the head entry in flight / next to send

    state_t           state_reg;
    logic [7:0]       timer_reg;

    logic [WIDTH-1:0] out_data_reg;
    logic             out_src_reg;
    logic             out_valid_reg;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             pair_nz;
    logic             fifo_full;
    logic             push;
    logic             accept;
    logic             pop;
    logic [PW-1:0]    cand_ptr;
    logic             cand_phase;
    logic             cand_avail;
    logic [WIDTH-1:0] cand_in1;
    logic [WIDTH-1:0] cand_in2;
    logic             cand_sel;
    logic [WIDTH-1:0] cand_word;
    logic             window_live;
    logic             load;

    always_comb begin
        pair_nz    = (in1 != '0) || (in2 != '0);
        // Full is judged on the registered level, so a pop in the same cycle
        // does not make room for this cycle's push.
        fifo_full  = (level_reg == LW'(DEPTH));
        push       = in_valid && pair_nz && !fifo_full;
        accept     = out_valid_reg && out_ready;

        // The in-flight word is the last one of its entry when it is the in2
        // half, or when the in2 half is zero and will be skipped.
        pop        = accept && (phase_reg || (mem_in2_reg[rd_ptr_reg] == '0));

        // Look past the word being accepted this cycle so the next word can
        // be loaded on the same edge (back-to-back words, no bubble).
        cand_ptr   = pop ? (rd_ptr_reg + 1'b1) : rd_ptr_reg;
        cand_phase = pop ? 1'b0 : (phase_reg | accept);
        cand_avail = pop ? (level_reg > LW'(1)) : (level_reg != '0);
        cand_in1   = mem_in1_reg[cand_ptr];
        cand_in2   = mem_in2_reg[cand_ptr];
        // A zero in1 half is skipped straight to in2
        cand_sel   = cand_phase || (cand_in1 == '0);
        cand_word  = cand_sel ? cand_in2 : cand_in1;

        // Loading is only allowed when the FSM stays ARMED after this edge,
        // so out_valid never rises as the window closes.
        window_live = (state_reg == ARMED) && ((timer_reg != 8'd0) || auth);
        load        = window_live && (!out_valid_reg || accept) && cand_avail;
    end

    // ------------------------------------------------------------------
    // Storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_in1_reg[wr_ptr_reg] <= in1;
            mem_in2_reg[wr_ptr_reg] <= in2;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and level
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window FSM, serializer phase and registered output word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= LOCKED;
            timer_reg     <= 8'd0;
            phase_reg     <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOCKED: begin
                    if (auth) begin
                        state_reg <= ARMED;
                        timer_reg <= 8'(TIMEOUT);
                    end
                end
                ARMED: begin
                    // auth wins over a same-cycle expiry
                    if (auth) begin
                        timer_reg <= 8'(TIMEOUT);
                    end else if (timer_reg != 8'd0) begin
                        timer_reg <= timer_reg - 8'd1;
                    end else if (out_valid_reg && !out_ready) begin
                        state_reg <= HOLD;
                    end else begin
                        state_reg <= LOCKED;
                    end
                end
                HOLD: begin
                    if (auth) begin
                        state_reg <= ARMED;
                        timer_reg <= 8'(TIMEOUT);
                    end else if (accept) begin
                        state_reg <= LOCKED;
                    end
                end
                default: begin
                    state_reg <= LOCKED;
                    timer_reg <= 8'd0;
                end
            endcase

            // phase survives window closure, so a half-sent entry resumes
            // with its in2 word at the next window
            if (load) begin
                out_data_reg  <= cand_word;
                out_src_reg   <= cand_sel;
                out_valid_reg <= 1'b1;
                phase_reg     <= cand_sel;
            end else if (accept) begin
                out_valid_reg <= 1'b0;
                phase_reg     <= cand_phase;
            end
        end
    end

`ifdef RELEASE_AUDIT_EN
    logic [7:0] dropped_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_cnt_reg <= 8'd0;
        end else if (in_valid && pair_nz && fifo_full && (dropped_cnt_reg != 8'hFF)) begin
            dropped_cnt_reg <= dropped_cnt_reg + 8'd1;
        end
    end

    assign dropped_cnt = dropped_cnt_reg;
`endif

    assign out_data    = out_data_reg;
    assign out_src     = out_src_reg;
    assign out_valid   = out_valid_reg;
    assign window_open = (state_reg != LOCKED);
    assign fifo_level  = level_reg;

endmodule

// File: tb/tb_release_gate_stage.sv
// -----------------------------------------------------------------------------
// tb_release_gate_stage
//
// Self-checking bench for release_gate_stage (DEPTH=4, TIMEOUT=4). Directed
// scenarios are followed by a randomized phase; every cycle the DUT is
// compared against a pair-queue reference model and a window model derived
// from the release rules (cycles since last auth, stranded words).
// -----------------------------------------------------------------------------
module tb_release_gate_stage;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int T  = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in1, in2;
    logic          in_valid, auth, out_ready;
    logic [W-1:0]  out_data;
    logic          out_src, out_valid, window_open;
    logic [LW-1:0] fifo_level;
`ifdef RELEASE_AUDIT_EN
    logic [7:0]    dropped_cnt;
`endif

    always #5 clk = ~clk;

    release_gate_stage #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in1         (in1),
        .in2         (in2),
        .in_valid    (in_valid),
        .auth        (auth),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .window_open (window_open),
`ifdef RELEASE_AUDIT_EN
        .fifo_level  (fifo_level),
        .dropped_cnt (dropped_cnt)
`else
        .fifo_level  (fifo_level)
`endif
    );

    // Reference model: queue of stored pairs; nxt = index of next half to emit
    typedef struct {
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        int           nxt;
    } ent_t;

    ent_t q[$];
    int   since;       // edges since auth was last sampled high
    bit   exp_open;
    int   exp_drops;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Next word the head pair must present, if any
    function automatic void head_word(output logic [W-1:0] w, output logic s, output bit ok);
        w  = '0;
        s  = 1'b0;
        ok = 1'b0;
        if (q.size() != 0) begin
            if (q[0].nxt == 0 && q[0].w1 != '0) begin
                w = q[0].w1; s = 1'b0; ok = 1'b1;
            end else if (q[0].w2 != '0) begin
                w = q[0].w2; s = 1'b1; ok = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        q.delete();
        since     = 1000;
        exp_open  = 1'b0;
        exp_drops = 0;
    endtask

    // One clock: sample inputs/outputs before the edge, update model, check #1 after
    task automatic step();
        logic [W-1:0] p_i1, p_i2, p_od, hw;
        logic         p_iv, p_au, p_rdy, p_ov, p_os, hs;
        bit           p_full, ok, stranded;
        p_i1 = in1; p_i2 = in2; p_iv = in_valid; p_au = auth; p_rdy = out_ready;
        p_ov = out_valid; p_od = out_data; p_os = out_src;
        p_full = (q.size() == D);
        @(posedge clk);
        #1;
        if (p_ov && p_rdy) begin
            head_word(hw, hs, ok);
            chk("accept_expected", 32'(ok), 32'd1);
            chk("accept_word", p_od, hw);
            chk("accept_src", 32'(p_os), 32'(hs));
            if (ok) begin
                if (!hs && q[0].w2 != '0) q[0].nxt = 1;
                else void'(q.pop_front());
            end
        end
        if (p_iv && (p_i1 != '0 || p_i2 != '0)) begin
            if (p_full) begin
                if (exp_drops < 255) exp_drops++;
            end else begin
                q.push_back('{w1: p_i1, w2: p_i2, nxt: 0});
            end
        end
        stranded = p_ov && !p_rdy;
        if (p_au) since = 0;
        else if (since < 1000) since++;
        exp_open = p_au ? 1'b1 : (since <= T) ? 1'b1 : (exp_open && stranded);

        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("window_open", 32'(window_open), 32'(exp_open));
        if (out_valid) begin
            head_word(hw, hs, ok);
            chk("present_expected", 32'(ok), 32'd1);
            chk("present_word", out_data, hw);
            chk("present_src", 32'(out_src), 32'(hs));
        end
        if (stranded) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, p_od);
            chk("hold_src", 32'(out_src), 32'(p_os));
        end
`ifdef RELEASE_AUDIT_EN
        chk("dropped_cnt", 32'(dropped_cnt), 32'(exp_drops));
`endif
        $display("cyc iv=%0b in=(%0h,%0h) auth=%0b rdy=%0b -> ov=%0b data=%0h src=%0b lvl=%0d win=%0b",
                 p_iv, p_i1, p_i2, p_au, p_rdy, out_valid, out_data, out_src, fifo_level, window_open);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_window", 32'(window_open), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
`ifdef RELEASE_AUDIT_EN
        chk("rst_dropped", 32'(dropped_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        chk("wait_valid_bound", 32'(out_valid), 32'd1);
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1; in1 = a; in2 = b;
        step();
        in_valid = 1'b0; in1 = '0; in2 = '0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; in1 = '0; in2 = '0; in_valid = 1'b0; auth = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        do_reset();
        step();

        // 1: reset while a word is presented
        in_valid = 1'b1; in1 = 32'h11; in2 = 32'h22; auth = 1'b1;
        step();
        in_valid = 1'b0; in1 = '0; in2 = '0; auth = 1'b0;
        wait_valid(10);
        do_reset();
        step();
        chk("t1_level", 32'(fifo_level), 32'd0);
        chk("t1_locked", 32'(window_open), 32'd0);

        // 2: stored pair held back without auth, then released back-to-back
        push_pair(32'd5, 32'd9);
        repeat (20) begin
            step();
            chk("t2_no_release", 32'(out_valid), 32'd0);
        end
        chk("t2_level", 32'(fifo_level), 32'd1);
        auth = 1'b1; out_ready = 1'b1;
        step();
        auth = 1'b0;
        step();
        chk("t2_w0_valid", 32'(out_valid), 32'd1);
        chk("t2_w0", out_data, 32'd5);
        chk("t2_w0_src", 32'(out_src), 32'd0);
        step();
        chk("t2_w1_valid", 32'(out_valid), 32'd1);
        chk("t2_w1", out_data, 32'd9);
        chk("t2_w1_src", 32'(out_src), 32'd1);
        step();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // 3: zero halves skipped, 2-cycle latency, all-zero pair ignored
        auth = 1'b1;
        in_valid = 1'b1; in1 = 32'd0; in2 = 32'd7;
        step();
        in1 = 32'd3; in2 = 32'd0;
        step();
        in_valid = 1'b0; in1 = '0; in2 = '0;
        chk("t3_latency_valid", 32'(out_valid), 32'd1);
        chk("t3_w0", out_data, 32'd7);
        chk("t3_w0_src", 32'(out_src), 32'd1);
        step();
        chk("t3_w1", out_data, 32'd3);
        chk("t3_w1_src", 32'(out_src), 32'd0);
        step();
        chk("t3_level_empty", 32'(fifo_level), 32'd0);
        push_pair(32'd0, 32'd0);
        chk("t3_zero_pair", 32'(fifo_level), 32'd0);
        auth = 1'b0;

        // 4: expiry with a stalled word -> HOLD, then LOCKED after accept
        out_ready = 1'b0;
        repeat (8) step();
        chk("t4_locked", 32'(window_open), 32'd0);
        push_pair(32'h44, 32'h55);
        auth = 1'b1;
        step();
        auth = 1'b0;
        repeat (10) step();
        chk("t4_hold_window", 32'(window_open), 32'd1);
        chk("t4_hold_valid", 32'(out_valid), 32'd1);
        chk("t4_hold_word", out_data, 32'h44);
        out_ready = 1'b1;
        step();
        chk("t4_after_valid", 32'(out_valid), 32'd0);
        chk("t4_after_window", 32'(window_open), 32'd0);
        auth = 1'b1;
        step();
        auth = 1'b0;
        step();
        chk("t4_resume_word", out_data, 32'h55);
        chk("t4_resume_src", 32'(out_src), 32'd1);
        step();

        // 5: overflow drops, drain yields first four pairs
        out_ready = 1'b0;
        repeat (8) step();
        push_pair(32'h11, 32'h12);
        push_pair(32'h00, 32'h22);
        push_pair(32'h31, 32'h00);
        push_pair(32'h41, 32'h42);
        push_pair(32'h51, 32'h52);
        push_pair(32'h61, 32'h62);
        chk("t5_full_level", 32'(fifo_level), 32'd4);
`ifdef RELEASE_AUDIT_EN
        chk("t5_dropped", 32'(dropped_cnt), 32'd2);
`endif
        auth = 1'b1; out_ready = 1'b1;
        repeat (12) step();
        chk("t5_drained", 32'(fifo_level), 32'd0);
        auth = 1'b0;

        // 6: window closes after in1 half; next window starts with in2
        out_ready = 1'b0;
        repeat (8) step();
        push_pair(32'd1, 32'd2);
        auth = 1'b1;
        step();
        auth = 1'b0;
        repeat (4) step();
        chk("t6_first_half", out_data, 32'd1);
        out_ready = 1'b1;
        step();
        chk("t6_closed_valid", 32'(out_valid), 32'd0);
        chk("t6_closed_window", 32'(window_open), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd1);
        auth = 1'b1;
        step();
        auth = 1'b0;
        step();
        chk("t6_resume_word", out_data, 32'd2);
        chk("t6_resume_src", 32'(out_src), 32'd1);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            in1       = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom();
            in2       = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom();
            auth      = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; in1 = '0; in2 = '0; auth = 1'b1; out_ready = 1'b1;
        repeat (20) step();
        chk("rand_drained", 32'(fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
